// File: rtl/rf_hazard_ctl_pkg.sv
// Shared constants and scoreboard types for the register-file interlock.
package rf_hazard_ctl_pkg;

    localparam int unsigned NREG_C  = 8;
    localparam int unsigned REGW_C  = 3;
    localparam int unsigned DEPTH_C = 3;
    localparam int unsigned CNTW_C  = 16;

    typedef enum logic [1:0] {
        SB_EX  = 2'd0,
        SB_MEM = 2'd1,
        SB_WB  = 2'd2
    } sb_stage_e;

    typedef struct packed {
        logic              v;
        logic [REGW_C-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/rf_sb_entry_match.sv
// Compares one register select against every in-flight scoreboard entry.
module rf_sb_entry_match
    import rf_hazard_ctl_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_C
) (
    input  sb_entry_t [DEPTH-1:0] sb_i,
    input  logic [REGW_C-1:0]     sel_i,
    output logic                  hit_o
);

    always_comb begin
        hit_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sb_i[i].v && (sb_i[i].rd == sel_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_hazard_ctl.sv
// Pipeline interlock: stalls decode on pending register writes, sequences
// redirect flushes and counts stall cycles.
module rf_hazard_ctl
    import rf_hazard_ctl_pkg::*;
#(
    parameter int unsigned NREG  = NREG_C,
    parameter int unsigned REGW  = REGW_C,
    parameter int unsigned DEPTH = DEPTH_C,
    parameter int unsigned CNTW  = CNTW_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic            id_rs_used,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_rt_used,
    input  logic            id_wr_en,
    input  logic [REGW-1:0] id_wr_reg,
    input  logic            ex_redirect,
    output logic            stall,
    output logic            ex_bubble,
    output logic            flush_id,
    output logic [NREG-1:0] pending,
    output logic [CNTW-1:0] stall_cnt
);

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [CNTW-1:0]       stall_cnt_q, stall_cnt_d;
    logic                  rs_hit, rt_hit, haz, issue;

    rf_sb_entry_match #(
        .DEPTH (DEPTH)
    ) u_match_rs (
        .sb_i  (sb_q),
        .sel_i (id_rs),
        .hit_o (rs_hit)
    );

    rf_sb_entry_match #(
        .DEPTH (DEPTH)
    ) u_match_rt (
        .sb_i  (sb_q),
        .sel_i (id_rt),
        .hit_o (rt_hit)
    );

    // Redirect wins: the ID instruction is dead, so its hazard is irrelevant.
    always_comb begin
        haz       = id_valid && ((id_rs_used && rs_hit) || (id_rt_used && rt_hit));
        flush_id  = ex_redirect;
        ex_bubble = ex_redirect || haz;
        stall     = !ex_redirect && haz;
        issue     = id_valid && id_wr_en && !stall && !ex_redirect;
    end

    always_comb begin
        sb_d          = '0;
        sb_d[SB_EX].v  = issue;
        sb_d[SB_EX].rd = issue ? id_wr_reg : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sb_q[i].v) begin
                pending[sb_q[i].rd] = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_hazard_ctl.sv
// Scoreboard bench for rf_hazard_ctl against a lifetime-based reference model.
module tb_rf_hazard_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic       id_wr_en = 1'b0, ex_redirect = 1'b0;
    logic [2:0] id_rs = '0, id_rt = '0, id_wr_reg = '0;

    logic        stall, ex_bubble, flush_id;
    logic [7:0]  pending;
    logic [15:0] stall_cnt;
    logic        stall8, ex_bubble8, flush_id8;
    logic [7:0]  pending8;
    logic [7:0]  stall_cnt8;

    always #5 clk = ~clk;

    rf_hazard_ctl u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .ex_redirect(ex_redirect), .stall(stall), .ex_bubble(ex_bubble), .flush_id(flush_id),
        .pending(pending), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    rf_hazard_ctl #(.CNTW(8)) u_dut8 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .ex_redirect(ex_redirect), .stall(stall8), .ex_bubble(ex_bubble8), .flush_id(flush_id8),
        .pending(pending8), .stall_cnt(stall_cnt8)
    );

    typedef struct packed {
        logic       v;
        logic [2:0] rs;
        logic       rsu;
        logic [2:0] rt;
        logic       rtu;
        logic       we;
        logic [2:0] wr;
        logic       redir;
    } in_t;

    typedef struct {
        logic        stall;
        logic        bub;
        logic        flush;
        logic [7:0]  pend;
        int unsigned cnt;
    } exp_t;

    typedef struct {
        logic [2:0]  r;
        int unsigned life;
    } fl_t;

    fl_t         fl[$];
    int unsigned m_cnt;
    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic busy(input logic [2:0] r);
        foreach (fl[i]) if (fl[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model_eval(input in_t x);
        exp_t e;
        logic h;
        h       = x.v && ((x.rsu && busy(x.rs)) || (x.rtu && busy(x.rt)));
        e.flush = x.redir;
        e.bub   = x.redir || h;
        e.stall = !x.redir && h;
        e.pend  = '0;
        foreach (fl[i]) e.pend[fl[i].r] = 1'b1;
        e.cnt   = m_cnt;
        return e;
    endfunction

    // A write stays visible for three clock edges after it is issued.
    task automatic model_advance(input in_t x, input logic st);
        fl_t keep[$];
        if (st) m_cnt++;
        foreach (fl[i]) if (fl[i].life > 1) keep.push_back('{r: fl[i].r, life: fl[i].life - 1});
        if (x.v && x.we && !st && !x.redir) keep.push_back('{r: x.wr, life: 3});
        fl = keep;
    endtask

    task automatic drive(input in_t x);
        id_valid    = x.v;
        id_rs       = x.rs;
        id_rs_used  = x.rsu;
        id_rt       = x.rt;
        id_rt_used  = x.rtu;
        id_wr_en    = x.we;
        id_wr_reg   = x.wr;
        ex_redirect = x.redir;
    endtask

    // Called at posedge+1: present inputs for one cycle, queue the expectation.
    task automatic step(input in_t x, output logic st);
        exp_t e;
        drive(x);
        e = model_eval(x);
        q.push_back(e);
        st = e.stall;
        @(posedge clk);
        model_advance(x, e.stall);
        #1;
    endtask

    // Hold an instruction in ID until it is admitted (bounded).
    task automatic issue(input in_t x);
        logic st;
        for (int k = 0; k < 10; k++) begin
            step(x, st);
            if (!st) return;
        end
        chk("issue_timeout", 32'(st), 32'(0));
    endtask

    function automatic in_t mk(input logic v, input logic [2:0] rs, input logic rsu,
                               input logic [2:0] rt, input logic rtu, input logic we,
                               input logic [2:0] wr, input logic redir);
        in_t x;
        x = '{v: v, rs: rs, rsu: rsu, rt: rt, rtu: rtu, we: we, wr: wr, redir: redir};
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst && q.size() > 0) begin
            e = q.pop_front();
            chk("stall",      32'(stall),      32'(e.stall));
            chk("ex_bubble",  32'(ex_bubble),  32'(e.bub));
            chk("flush_id",   32'(flush_id),   32'(e.flush));
            chk("pending",    32'(pending),    32'(e.pend));
            chk("stall_cnt",  32'(stall_cnt),  (e.cnt > 32'hFFFF) ? 32'hFFFF : e.cnt);
            chk("stall_cnt8", 32'(stall_cnt8), (e.cnt > 32'hFF) ? 32'hFF : e.cnt);
        end
    end

    task automatic reset_seq();
        drive('0);
        rst = 1'b0;
        fl.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",   32'(stall),     32'(0));
        chk("rst_pending", 32'(pending),   32'(0));
        chk("rst_cnt",     32'(stall_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic st;
        exp_t e;
        in_t  idle, x;
        idle = '0;

        reset_seq();
        repeat (5) step(idle, st);

        // Back-to-back RAW on r3 via rs.
        issue(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd3, 0));
        issue(mk(1, 3'd3, 1, 3'd1, 0, 1, 3'd4, 0));
        repeat (4) step(idle, st);

        // One-instruction gap, reader via rt; then same with rt unused.
        issue(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 0));
        issue(mk(1, 3'd1, 0, 3'd2, 0, 1, 3'd1, 0));
        issue(mk(1, 3'd0, 0, 3'd5, 1, 0, 3'd0, 0));
        repeat (4) step(idle, st);
        issue(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd5, 0));
        issue(mk(1, 3'd1, 0, 3'd2, 0, 1, 3'd1, 0));
        issue(mk(1, 3'd0, 0, 3'd5, 0, 0, 3'd0, 0));
        repeat (4) step(idle, st);

        // Redirect over a hazard on r2.
        issue(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd2, 0));
        step(mk(1, 3'd2, 1, 3'd2, 1, 1, 3'd6, 1), st);
        step(mk(1, 3'd6, 1, 3'd0, 0, 0, 3'd0, 1), st);
        repeat (4) step(idle, st);

        // Link write then second writer to r7; both sources equal and pending.
        issue(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd7, 0));
        issue(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd7, 0));
        repeat (5) step(idle, st);
        issue(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd6, 0));
        issue(mk(1, 3'd6, 1, 3'd6, 1, 0, 3'd0, 0));
        // id_valid=0 with both sources marked used on a pending register.
        step(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd4, 0), st);
        step(mk(0, 3'd4, 1, 3'd4, 1, 1, 3'd4, 0), st);
        repeat (4) step(idle, st);

        // Async reset asserted between edges while stalled.
        issue(mk(1, 3'd0, 0, 3'd0, 0, 1, 3'd3, 0));
        x = mk(1, 3'd3, 1, 3'd0, 0, 0, 3'd0, 0);
        drive(x);
        e = model_eval(x);
        #2;
        chk("pre_rst_stall", 32'(stall), 32'(e.stall));
        rst = 1'b0;
        #1;
        chk("async_stall",   32'(stall),     32'(0));
        chk("async_bubble",  32'(ex_bubble), 32'(0));
        chk("async_pending", 32'(pending),   32'(0));
        chk("async_cnt",     32'(stall_cnt), 32'(0));
        reset_seq();
        repeat (2) step(idle, st);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            x.v     = ($urandom_range(0, 9) != 0);
            x.rs    = 3'($urandom_range(0, 7));
            x.rsu   = 1'($urandom);
            x.rt    = 3'($urandom_range(0, 7));
            x.rtu   = 1'($urandom);
            x.we    = ($urandom_range(0, 3) != 0);
            x.wr    = 3'($urandom_range(0, 7));
            x.redir = ($urandom_range(0, 11) == 0);
            step(x, st);
        end

        // Self-dependent chain drives the narrow counter into saturation.
        for (int n = 0; n < 400; n++) begin
            x = mk(1, 3'd1, 1, 3'($urandom_range(0, 7)), 1'($urandom), 1, 3'd1, 0);
            step(x, st);
        end
        repeat (4) step(idle, st);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
